// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and framing defaults shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: valid/ready byte handshake into the UART transmitter's holding register.
interface uart_transmitter_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 data_valid;
  logic                 ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: LSB-first serialiser with a one-entry holding register, OVERSAMPLE cycles per bit.
// Optional even-parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic              sample_clk,
  input  logic              rstn,
  uart_transmitter_if.slave tx_if,
  output logic              serial_out,
  output logic              busy
);

  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS) + 1;
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] DATA_LAST   = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST   = BCW'(STOP_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [SCW-1:0]       sample_cnt, sample_cnt_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [DATA_BITS-1:0] hold_reg, hold_reg_nxt;
  logic                 hold_full, hold_full_nxt;
  logic                 bit_end;
  logic                 load;

  assign tx_if.ready = ~hold_full;
  assign busy        = (state != IDLE);
  assign bit_end     = (sample_cnt == SAMPLE_LAST);

  always_comb begin
    state_nxt      = state;
    sample_cnt_nxt = sample_cnt;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift_reg;
    hold_reg_nxt   = hold_reg;
    hold_full_nxt  = hold_full;
    load           = 1'b0;

    if (tx_if.data_valid && !hold_full) begin
      hold_reg_nxt  = tx_if.data_in;
      hold_full_nxt = 1'b1;
    end

    if (state != IDLE) begin
      sample_cnt_nxt = bit_end ? '0 : sample_cnt + SCW'(1);
    end

    case (state)
      IDLE: begin
        if (hold_full) load = 1'b1;
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt   = shift_reg >> 1;
          bit_cnt_nxt = bit_cnt + BCW'(1);
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        // bit_cnt is reused to count stop bit periods
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_nxt = '0;
            if (hold_full) load = 1'b1;
            else           state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + BCW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Load has no accept to collide with: it only fires while hold_full is set.
    if (load) begin
      state_nxt      = START;
      shift_nxt      = hold_reg;
      hold_full_nxt  = 1'b0;
      sample_cnt_nxt = '0;
      bit_cnt_nxt    = '0;
    end
  end

  always_ff @(posedge sample_clk) begin
    if (!rstn) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= sample_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_reg  <= shift_nxt;
      hold_reg   <= hold_reg_nxt;
      hold_full  <= hold_full_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_reg;

  always_ff @(posedge sample_clk) begin
    if (!rstn) begin
      parity_reg <= 1'b0;
    end else if (load) begin
      parity_reg <= ^hold_reg;
    end
  end
`endif

  always_comb begin
    serial_out = 1'b1;
    case (state)
      START:   serial_out = 1'b0;
      DATA:    serial_out = shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_out = parity_reg;
`endif
      default: serial_out = 1'b1;
    endcase
  end

endmodule
